cnn_sweep_ctrl: RTL and testbench

//  Sequencer for the time-multiplexed 4x4 CNN array (one shared cell, 16 slots per sweep).
//  Per run: loads the initial state, issues full sweeps of 16 cell slots, and tracks the

---
 rtl/cnn_sweep_if.sv | 33 +++
 rtl/cnn_sweep_ctrl.sv | 136 +++++++++++++
 tb/tb_cnn_sweep_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_sweep_if.sv
// cnn_sweep_if: host/array handshake bundle for the CNN sweep sequencer
interface cnn_sweep_if #(
    parameter int DATA_W = 18,
    parameter int ITER_W = 8,
    parameter int IDX_W  = 4
);
    logic                     start;
    logic                     abort;
    logic [ITER_W-1:0]        num_iter;
    logic [DATA_W-1:0]        thresh;
    logic                     upd_valid;
    logic                     upd_last;
    logic signed [DATA_W-1:0] y_new;
    logic signed [DATA_W-1:0] y_old;
    logic                     load_init;
    logic                     slot_valid;
    logic [IDX_W-1:0]         cell_idx;
    logic                     busy;
    logic                     done;
    logic                     converged;
    logic [ITER_W-1:0]        iters_done;
    logic                     err;

    modport master (
        output start, abort, num_iter, thresh, upd_valid, upd_last, y_new, y_old,
        input  load_init, slot_valid, cell_idx, busy, done, converged, iters_done, err
    );

    modport slave (
        input  start, abort, num_iter, thresh, upd_valid, upd_last, y_new, y_old,
        output load_init, slot_valid, cell_idx, busy, done, converged, iters_done, err
    );
endinterface

// File: rtl/cnn_sweep_ctrl.sv
// cnn_sweep_ctrl: sweep sequencer for the time-multiplexed 4x4 CNN array with convergence tracking
module cnn_sweep_ctrl #(
    parameter int DATA_W  = 18,
    parameter int ITER_W  = 8,
    parameter int CELLS   = 16,
    parameter int IDX_W   = 4,
    parameter int CONV_EN = 1
) (
    input logic        clk,
    input logic        rst,
    cnn_sweep_if.slave bus
);
    localparam int CNT_W = IDX_W + 2;
    localparam logic [CNT_W-1:0] CELLS_C  = CNT_W'(CELLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SWEEP, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cell_idx_q, cell_idx_d;
    logic [ITER_W-1:0] sweep_cnt_q, sweep_cnt_d;
    logic [ITER_W-1:0] num_iter_q, num_iter_d;
    logic [ITER_W-1:0] iters_done_q, iters_done_d;
    logic [DATA_W-1:0] thresh_q, thresh_d;
    logic [DATA_W:0]   max_diff_q, max_diff_d;
    logic [CNT_W-1:0]  upd_cnt_q, upd_cnt_d;
    logic              converged_q, converged_d;
    logic              err_q, err_d;

    logic [DATA_W:0]   diff, abs_diff, max_acc;
    logic [CNT_W-1:0]  cnt_acc;
    logic [ITER_W-1:0] sweep_nxt;
    logic              accept, last, conv_hit, enter_sweep;

    // Sign-extend by one bit so the full signed range difference never overflows.
    assign diff      = {bus.y_new[DATA_W-1], bus.y_new} - {bus.y_old[DATA_W-1], bus.y_old};
    assign abs_diff  = diff[DATA_W] ? -diff : diff;
    assign max_acc   = (abs_diff > max_diff_q) ? abs_diff : max_diff_q;
    assign cnt_acc   = (&upd_cnt_q) ? upd_cnt_q : upd_cnt_q + CNT_W'(1);
    assign accept    = (state_q == S_SWEEP || state_q == S_WAIT) && bus.upd_valid && !bus.abort;
    assign last      = accept && bus.upd_last;
    assign sweep_nxt = sweep_cnt_q + ITER_W'(1);
    assign conv_hit  = (CONV_EN != 0) && (max_acc <= {1'b0, thresh_q});

    assign bus.load_init  = (state_q == S_LOAD);
    assign bus.slot_valid = (state_q == S_SWEEP);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.cell_idx   = cell_idx_q;
    assign bus.converged  = converged_q;
    assign bus.iters_done = iters_done_q;
    assign bus.err        = err_q;

    // Next-state, sweep bookkeeping and end-of-sweep evaluation.
    always_comb begin
        state_d      = state_q;
        sweep_cnt_d  = sweep_cnt_q;
        num_iter_d   = num_iter_q;
        iters_done_d = iters_done_q;
        thresh_d     = thresh_q;
        max_diff_d   = accept ? max_acc : max_diff_q;
        upd_cnt_d    = accept ? cnt_acc : upd_cnt_q;
        converged_d  = converged_q;
        err_d        = err_q;
        enter_sweep  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d      = S_LOAD;
                    num_iter_d   = (bus.num_iter == '0) ? ITER_W'(1) : bus.num_iter;
                    thresh_d     = bus.thresh;
                    converged_d  = 1'b0;
                    iters_done_d = '0;
                    err_d        = 1'b0;
                end
            end
            S_LOAD: begin
                state_d     = bus.abort ? S_IDLE : S_SWEEP;
                enter_sweep = !bus.abort;
                sweep_cnt_d = '0;
            end
            S_SWEEP, S_WAIT: begin
                if (state_q == S_SWEEP && cell_idx_q == LAST_IDX) state_d = S_WAIT;
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (last) begin
                    if (cnt_acc != CELLS_C) err_d = 1'b1;
                    if (conv_hit || sweep_nxt >= num_iter_q) begin
                        converged_d  = conv_hit;
                        iters_done_d = sweep_nxt;
                        state_d      = S_DONE;
                    end else begin
                        sweep_cnt_d = sweep_nxt;
                        state_d     = S_SWEEP;
                        enter_sweep = 1'b1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (enter_sweep) begin
            max_diff_d = '0;
            upd_cnt_d  = '0;
        end
        cell_idx_d = (!enter_sweep && state_q == S_SWEEP && state_d == S_SWEEP)
                     ? cell_idx_q + IDX_W'(1) : '0;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cell_idx_q   <= '0;
            sweep_cnt_q  <= '0;
            num_iter_q   <= '0;
            iters_done_q <= '0;
            thresh_q     <= '0;
            max_diff_q   <= '0;
            upd_cnt_q    <= '0;
            converged_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cell_idx_q   <= cell_idx_d;
            sweep_cnt_q  <= sweep_cnt_d;
            num_iter_q   <= num_iter_d;
            iters_done_q <= iters_done_d;
            thresh_q     <= thresh_d;
            max_diff_q   <= max_diff_d;
            upd_cnt_q    <= upd_cnt_d;
            converged_q  <= converged_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_cnn_sweep_ctrl.sv
// tb_cnn_sweep_ctrl: directed self-checking bench with a fixed-latency array responder
module tb_cnn_sweep_ctrl;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    logic start, abort, upd_valid, upd_last;
    logic [7:0] num_iter;
    logic [17:0] thresh;
    logic signed [17:0] y_new, y_old;
    logic sel;

    logic o_load, o_slot, o_busy, o_done, o_conv, o_err;
    logic [3:0] o_idx;
    logic [7:0] o_iters;

    int checks = 0;
    int failures = 0;

    int cyc = 100;
    logic h_v [64];
    logic [3:0] h_i [64];
    int asweep, exp_idx, skip_idx, skip_sweep, start_at;
    int diffs [8];
    bit extreme;
    int n_load, n_slot, n_done, n_burst, idx_err, err_mid;

    cnn_sweep_if #(.DATA_W(18), .ITER_W(8), .IDX_W(4)) a_if ();
    cnn_sweep_if #(.DATA_W(18), .ITER_W(8), .IDX_W(4)) b_if ();

    cnn_sweep_ctrl #(.CONV_EN(1)) dut0 (.clk(clk), .rst(rst), .bus(a_if));
    cnn_sweep_ctrl #(.CONV_EN(0)) dut1 (.clk(clk), .rst(rst), .bus(b_if));

    assign a_if.start = start;      assign b_if.start = start;
    assign a_if.abort = abort;      assign b_if.abort = abort;
    assign a_if.num_iter = num_iter; assign b_if.num_iter = num_iter;
    assign a_if.thresh = thresh;    assign b_if.thresh = thresh;
    assign a_if.upd_valid = upd_valid; assign b_if.upd_valid = upd_valid;
    assign a_if.upd_last = upd_last; assign b_if.upd_last = upd_last;
    assign a_if.y_new = y_new;      assign b_if.y_new = y_new;
    assign a_if.y_old = y_old;      assign b_if.y_old = y_old;

    assign o_load  = sel ? b_if.load_init  : a_if.load_init;
    assign o_slot  = sel ? b_if.slot_valid : a_if.slot_valid;
    assign o_busy  = sel ? b_if.busy       : a_if.busy;
    assign o_done  = sel ? b_if.done       : a_if.done;
    assign o_conv  = sel ? b_if.converged  : a_if.converged;
    assign o_err   = sel ? b_if.err        : a_if.err;
    assign o_idx   = sel ? b_if.cell_idx   : a_if.cell_idx;
    assign o_iters = sel ? b_if.iters_done : a_if.iters_done;

    always #5 clk = ~clk;

    task automatic tick();
        int k;
        int dv;
        @(posedge clk);
        #1;
        cyc++;
        if (o_load) n_load++;
        if (o_done) n_done++;
        if (o_busy && o_err) err_mid++;
        if (o_slot) begin
            n_slot++;
            if (o_idx == 4'd0) n_burst++;
            if (int'(o_idx) != exp_idx) idx_err++;
            exp_idx = (exp_idx + 1) % 16;
        end
        h_v[cyc % 64] = o_slot;
        h_i[cyc % 64] = o_idx;
        k = (cyc - LAT) % 64;
        upd_valid = h_v[k] && !(asweep == skip_sweep && int'(h_i[k]) == skip_idx);
        upd_last  = h_v[k] && (h_i[k] == 4'd15);
        dv = (asweep < 8) ? diffs[asweep] : 0;
        if (extreme) begin
            y_new = 18'sd131071;
            y_old = -18'sd131072;
        end else if (h_i[k][0]) begin
            y_new = '0;
            y_old = 18'(dv);
        end else begin
            y_new = 18'(dv);
            y_old = '0;
        end
        if (upd_last) asweep++;
    endtask

    task automatic run_begin(input int ni, input int th);
        n_load = 0; n_slot = 0; n_done = 0; n_burst = 0; idx_err = 0; err_mid = 0;
        asweep = 0; exp_idx = 0;
        num_iter = 8'(ni);
        thresh = 18'(th);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_finish(input int maxc, input string name);
        for (int c = 0; c < maxc && n_done == 0; c++) begin
            start = (c == start_at);
            tick();
        end
        start = 1'b0;
        checks++;
        if (n_done != 1) begin
            failures++;
            $display("FAIL %s_done_timeout got=%0d exp=1", name, n_done);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++;
        if ({o_load, o_slot, o_busy, o_done, o_conv, o_err, o_idx, o_iters} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {o_load, o_slot, o_busy, o_done, o_conv, o_err, o_idx, o_iters});
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic_sweeps();
        for (int i = 0; i < 8; i++) diffs[i] = 10;
        run_begin(3, 0);
        checks++;
        if (o_load !== 1'b1) begin failures++; $display("FAIL t1_load_init got=%b exp=1", o_load); end
        run_finish(200, "t1");
        checks++;
        if (n_load != 1) begin failures++; $display("FAIL t1_load_count got=%0d exp=1", n_load); end
        checks++;
        if (n_slot != 48 || n_burst != 3) begin failures++; $display("FAIL t1_slots got=%0d/%0d exp=48/3", n_slot, n_burst); end
        checks++;
        if (idx_err != 0) begin failures++; $display("FAIL t1_idx_seq got=%0d exp=0", idx_err); end
        checks++;
        if (o_iters !== 8'd3 || o_conv !== 1'b0) begin failures++; $display("FAIL t1_result got=%0d/%b exp=3/0", o_iters, o_conv); end
        tick();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL t1_done_pulse got=%b/%b exp=0/0", o_done, o_busy); end
        idle(4);
    endtask

    task automatic test_convergence();
        diffs[0] = 40; diffs[1] = 5; diffs[2] = 0;
        run_begin(10, 5);
        run_finish(200, "t2");
        checks++;
        if (o_iters !== 8'd2 || o_conv !== 1'b1) begin failures++; $display("FAIL t2_result got=%0d/%b exp=2/1", o_iters, o_conv); end
        idle(20);
        checks++;
        if (n_slot != 32 || n_burst != 2) begin failures++; $display("FAIL t2_slots got=%0d/%0d exp=32/2", n_slot, n_burst); end
        checks++;
        if (o_conv !== 1'b1 || o_iters !== 8'd2) begin failures++; $display("FAIL t2_hold got=%0d/%b exp=2/1", o_iters, o_conv); end
    endtask

    task automatic test_iter_limits();
        for (int i = 0; i < 8; i++) diffs[i] = 10;
        run_begin(0, 0);
        run_finish(200, "t3a");
        checks++;
        if (o_iters !== 8'd1 || n_slot != 16) begin failures++; $display("FAIL t3_num_iter0 got=%0d/%0d exp=1/16", o_iters, n_slot); end
        for (int i = 0; i < 8; i++) diffs[i] = 0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        sel = 1'b1;
        idle(4);
        run_begin(4, 100);
        run_finish(500, "t3b");
        checks++;
        if (o_iters !== 8'd4 || o_conv !== 1'b0 || n_slot != 64) begin
            failures++;
            $display("FAIL t3_conv_disabled got=%0d/%b/%0d exp=4/0/64", o_iters, o_conv, n_slot);
        end
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        sel = 1'b0;
        idle(4);
    endtask

    task automatic test_abort_restart();
        int seen;
        for (int i = 0; i < 8; i++) diffs[i] = 10;
        run_begin(3, 0);
        seen = 0;
        for (int c = 0; c < 50 && seen == 0; c++) begin
            tick();
            if (o_slot && o_idx == 4'd7) seen = 1;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (seen != 1 || o_slot !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL t4_abort got=seen%0d/%b/%b exp=1/0/0", seen, o_slot, o_busy);
        end
        idle(10);
        checks++;
        if (n_done != 0 || o_iters !== 8'd0) begin failures++; $display("FAIL t4_no_done got=%0d/%0d exp=0/0", n_done, o_iters); end
        run_begin(2, 0);
        start_at = 5;
        run_finish(200, "t4");
        start_at = -1;
        checks++;
        if (o_iters !== 8'd2 || n_load != 1 || n_slot != 32 || idx_err != 0) begin
            failures++;
            $display("FAIL t4_restart got=%0d/%0d/%0d/%0d exp=2/1/32/0", o_iters, n_load, n_slot, idx_err);
        end
        idle(4);
    endtask

    task automatic test_err_extreme();
        skip_sweep = 0; skip_idx = 4;
        run_begin(2, 0);
        run_finish(200, "t5a");
        skip_sweep = -1; skip_idx = -1;
        checks++;
        if (o_err !== 1'b1 || err_mid == 0 || o_iters !== 8'd2) begin
            failures++;
            $display("FAIL t5_err_set got=%b/%0d/%0d exp=1/>0/2", o_err, err_mid, o_iters);
        end
        idle(4);
        checks++;
        if (o_err !== 1'b1) begin failures++; $display("FAIL t5_err_held got=%b exp=1", o_err); end
        extreme = 1'b1;
        run_begin(1, 262142);
        checks++;
        if (o_load !== 1'b1 || o_err !== 1'b0) begin failures++; $display("FAIL t5_err_clear got=%b/%b exp=1/0", o_load, o_err); end
        run_finish(200, "t5b");
        checks++;
        if (o_conv !== 1'b0 || o_iters !== 8'd1 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL t5_extreme_under got=%b/%0d/%b exp=0/1/0", o_conv, o_iters, o_err);
        end
        idle(4);
        run_begin(1, 262143);
        run_finish(200, "t5c");
        checks++;
        if (o_conv !== 1'b1) begin failures++; $display("FAIL t5_extreme_equal got=%b exp=1", o_conv); end
        extreme = 1'b0;
        idle(4);
    endtask

    task automatic test_reset_in_wait();
        int seen;
        for (int i = 0; i < 8; i++) diffs[i] = 10;
        run_begin(3, 0);
        seen = 0;
        for (int c = 0; c < 50 && seen == 0; c++) begin
            tick();
            if (o_slot && o_idx == 4'd15) seen = 1;
        end
        tick();
        checks++;
        if (seen != 1 || o_busy !== 1'b1 || o_slot !== 1'b0) begin
            failures++;
            $display("FAIL t6_in_wait got=seen%0d/%b/%b exp=1/1/0", seen, o_busy, o_slot);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({o_load, o_slot, o_busy, o_done, o_conv, o_err, o_idx, o_iters} !== '0) begin
            failures++;
            $display("FAIL t6_reset_outputs got=%b exp=0", {o_load, o_slot, o_busy, o_done, o_conv, o_err, o_idx, o_iters});
        end
        idle(4);
        run_begin(1, 0);
        checks++;
        if (o_load !== 1'b1) begin failures++; $display("FAIL t6_restart_load got=%b exp=1", o_load); end
        run_finish(200, "t6");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; upd_valid = 1'b0; upd_last = 1'b0;
        num_iter = '0; thresh = '0; y_new = '0; y_old = '0; sel = 1'b0;
        extreme = 1'b0; skip_idx = -1; skip_sweep = -1; start_at = -1;
        for (int i = 0; i < 64; i++) begin h_v[i] = 1'b0; h_i[i] = '0; end
        for (int i = 0; i < 8; i++) diffs[i] = 0;
        test_reset();
        test_basic_sweeps();
        test_convergence();
        test_iter_limits();
        test_abort_restart();
        test_err_extreme();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
